// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the select lines of an 8:1 channel mux, walking
// the enabled channels in ascending order. Each mux sample is registered and
// offered as a (channel, data) pair on a valid/ready stream. The bench can run
// a single pass or scan continuously until stopped.
`timescale 1ns/1ps

module mux_scan_sequencer #(
    parameter int DW  = 4,
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    output logic [2:0]     sel,
    input  logic [DW-1:0]  mux_f,
    output logic [DW-1:0]  out_data,
    output logic [2:0]     out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;

    state_t         state;
    logic [2:0]     ch;
    logic [NCH-1:0] mask_q;
    logic           cont_q;
    logic           stop_q;

    // {found, index} of the lowest set bit of m
    function automatic logic [3:0] lowest_ch(input logic [NCH-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit of m strictly above channel c
    function automatic logic [3:0] next_ch(input logic [NCH-1:0] m, input logic [2:0] c);
        logic [3:0] r;
        r = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k] && (k > int'(c))) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    logic [3:0] first_sel;  // first channel of a new scan, from the live mask
    logic [3:0] above_sel;  // next channel in the current pass
    logic [3:0] wrap_sel;   // first channel of the next pass in continuous mode

    assign first_sel = lowest_ch(ch_mask);
    assign above_sel = next_ch(mask_q, ch);
    assign wrap_sel  = lowest_ch(mask_q);

    // Scan FSM with all outputs registered; sel mirrors ch while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            // stop is remembered and only consulted at the wrap decision
            if (busy && stop) stop_q <= 1'b1;

            case (state)
                IDLE: begin
                    sel <= '0;
                    if (start) begin
                        mask_q <= ch_mask;
                        cont_q <= cont;
                        if (!first_sel[3]) begin
                            done <= 1'b1;
                        end else begin
                            ch    <= first_sel[2:0];
                            sel   <= first_sel[2:0];
                            busy  <= 1'b1;
                            state <= SELECT;
                        end
                    end
                end

                SELECT: begin
                    // mux_f has settled on sel=ch for a full cycle
                    out_data  <= mux_f;
                    out_ch    <= ch;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end

                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (above_sel[3]) begin
                            ch    <= above_sel[2:0];
                            sel   <= above_sel[2:0];
                            state <= SELECT;
                        end else if (cont_q && !stop_q && wrap_sel[3]) begin
                            ch    <= wrap_sel[2:0];
                            sel   <= wrap_sel[2:0];
                            state <= SELECT;
                        end else begin
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            sel    <= '0;
                            stop_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    sel   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural 8:1 mux driven from sel, a
// transaction scoreboard of the expected channel order, a table of scans with
// known outcomes, and hand-written backpressure/stop/reset sequences.
`timescale 1ns/1ps

module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] ch_mask;
    logic [2:0] sel;
    logic [3:0] mux_f;
    logic [3:0] out_data;
    logic [2:0] out_ch;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [3:0] mem [8];
    assign mux_f = mem[sel];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DW(4), .NCH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .sel       (sel),
        .mux_f     (mux_f),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [7:0] mask;
        int         n;
        int         first;
        int         last;
        int         cyc;
    } vec_t;

    vec_t       tbl [6];
    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    int         xfers;
    int         done_cnt;
    int         first_ch;
    int         last_ch;
    logic [7:0] mask_cur;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Score the handshake about to happen with the inputs as now driven, then
    // advance one clock to the next falling edge.
    task automatic tick();
        int e;
        if (out_valid && out_ready) begin
            xfers++;
            if (first_ch < 0) first_ch = int'(out_ch);
            last_ch = int'(out_ch);
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", int'(out_ch), -1);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_ch", int'(out_ch), e);
                chk("xfer_data", int'(out_data), int'(mem[e[2:0]]));
            end
        end
        if (busy) chk("sel_enabled", int'(mask_cur[sel]), 1);
        @(negedge clk);
        if (done) begin
            done_cnt++;
            chk("busy_at_done", int'(busy), 0);
        end
    endtask

    // Expected order of a single pass: enabled channels, ascending.
    task automatic begin_scan(input logic [7:0] m, input logic c);
        exp_q.delete();
        for (int k = 0; k < 8; k++) if (m[k]) exp_q.push_back(k);
        mask_cur = m;
        xfers    = 0;
        done_cnt = 0;
        first_ch = -1;
        last_ch  = -1;
        ch_mask  = m;
        cont     = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ch_mask  = 8'($urandom);
        cont     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input bit rnd, input int budget, output int n);
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("done_seen", done_cnt, 1);
        chk("valid_after_done", int'(out_valid), 0);
        chk("leftover_expected", exp_q.size(), 0);
    endtask

    task automatic rand_mem();
        for (int k = 0; k < 8; k++) mem[k] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int n;
        tbl[0] = '{8'hFF, 8, 0, 7, 16};
        tbl[1] = '{8'hA4, 3, 2, 7, 6};
        tbl[2] = '{8'h81, 2, 0, 7, 4};
        tbl[3] = '{8'h08, 1, 3, 3, 2};
        tbl[4] = '{8'h80, 1, 7, 7, 2};
        tbl[5] = '{8'h00, 0, -1, -1, 0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
        ch_mask = '0; out_ready = 1'b1; mask_cur = '0;
        xfers = 0; done_cnt = 0; first_ch = -1; last_ch = -1;
        for (int k = 0; k < 8; k++) mem[k] = 4'((k + 3) % 16);

        repeat (2) @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full pass with data = channel + 3, including first-sample latency
        begin_scan(8'hFF, 1'b0);
        chk("lat_select_valid", int'(out_valid), 0);
        chk("lat_busy", int'(busy), 1);
        tick();
        chk("lat_send_valid", int'(out_valid), 1);
        chk("lat_send_ch", int'(out_ch), 0);
        chk("lat_send_data", int'(out_data), 3);
        wait_done(1'b0, 100, n);
        chk("full_cycles", n + 1, 16);
        chk("full_xfers", xfers, 8);

        // Table of single-pass scans with out_ready held high
        for (int i = 0; i < 6; i++) begin
            rand_mem();
            begin_scan(tbl[i].mask, 1'b0);
            wait_done(1'b0, 100, n);
            chk("tbl_xfers", xfers, tbl[i].n);
            chk("tbl_first", first_ch, tbl[i].first);
            chk("tbl_last", last_ch, tbl[i].last);
            chk("tbl_cycles", n, tbl[i].cyc);
        end

        // Backpressure on channel 3
        rand_mem();
        begin_scan(8'hFF, 1'b0);
        n = 0;
        while (!(out_valid && out_ch == 3'd3) && n < 50) begin
            tick();
            n++;
        end
        chk("bp_reached_ch3", int'(out_valid && out_ch == 3'd3), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_ch", int'(out_ch), 3);
            chk("bp_data", int'(out_data), int'(mem[3]));
            chk("bp_sel", int'(sel), 3);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_adv_sel", int'(sel), 4);
        chk("bp_adv_valid", int'(out_valid), 0);
        tick();
        chk("bp_next_ch", int'(out_ch), 4);
        chk("bp_next_valid", int'(out_valid), 1);
        wait_done(1'b0, 100, n);

        // Continuous 0,7,0,7,... then stop during channel 0 of the fourth pass
        rand_mem();
        begin_scan(8'h81, 1'b1);
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(0);
            exp_q.push_back(7);
        end
        n = 0;
        while (xfers < 6 && n < 100) begin
            tick();
            n++;
        end
        chk("cont_six_xfers", xfers, 6);
        chk("cont_no_early_done", done_cnt, 0);
        chk("cont_wrap_sel", int'(sel), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(1'b0, 100, n);
        chk("stop_total_xfers", xfers, 8);
        repeat (4) tick();
        chk("stop_no_wrap", xfers, 8);

        // Empty mask: done only; start honoured in that same done cycle
        begin_scan(8'h00, 1'b1);
        chk("empty_done_now", int'(done), 1);
        chk("empty_busy", int'(busy), 0);
        chk("empty_valid", int'(out_valid), 0);
        wait_done(1'b0, 10, n);
        chk("empty_xfers", xfers, 0);
        begin_scan(8'h08, 1'b0);
        // Start while busy with a wider mask and cont: must be ignored
        ch_mask = 8'hFF;
        cont    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(1'b0, 50, n);
        chk("busy_start_xfers", xfers, 1);
        repeat (3) tick();
        chk("busy_start_idle", int'(busy), 0);

        // Asynchronous reset in SEND with out_valid high
        rand_mem();
        out_ready = 1'b0;
        begin_scan(8'hFF, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("rst_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(sel), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_ch", int'(out_ch), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        exp_q.delete();
        mask_cur = '0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        begin_scan(8'h30, 1'b0);
        wait_done(1'b0, 50, n);
        chk("post_rst_first", first_ch, 4);
        chk("post_rst_xfers", xfers, 2);

        // Random masks and data with random backpressure
        for (int i = 0; i < 12; i++) begin
            logic [7:0] m;
            int         pc;
            rand_mem();
            m  = 8'($urandom);
            pc = $countones(m);
            begin_scan(m, 1'b0);
            wait_done(1'b1, 400, n);
            chk("rand_xfers", xfers, pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
